// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between the instruction fetcher and the LSU.
// Optional macro MEM_ARB_ROUND_ROBIN_EN swaps fixed data priority for round-robin.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  inst_ready,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  input  logic                  data_we,
  input  logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  grant_data
);

  // Handshake: a requester holds valid/addr (and wdata/we) until its ready
  // pulses for one cycle; read data is sampled on that pulse. The memory side
  // sees the same convention on mem_valid/mem_ready.

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_INST = 2'd1,
    GRANT_DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_data_q, grant_data_d;
  logic   pick_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_last_q = 1 when the most recent grant went to the data side.
  logic rr_last_q, rr_last_d;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick_data = data_valid & (~inst_valid | ~rr_last_q);
    rr_last_d = rr_last_q;
`else
    pick_data    = data_valid & (~inst_valid | (starve_cnt_q < LIMIT));
    starve_cnt_d = starve_cnt_q;
`endif
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_data) begin
          state_d = GRANT_DATA;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_last_d = 1'b1;
`else
          if (inst_valid)
            starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
          else
            starve_cnt_d = 4'd0;
`endif
        end else if (inst_valid) begin
          state_d = GRANT_INST;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_last_d = 1'b0;
`else
          starve_cnt_d = 4'd0;
`endif
        end
      end
      // A dropped valid before mem_ready is an abort: back to IDLE, no pulse.
      GRANT_INST: if (mem_ready || !inst_valid) state_d = IDLE;
      GRANT_DATA: if (mem_ready || !data_valid) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    grant_data_d = (state_d == GRANT_DATA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_data_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_last_q    <= 1'b0;
`else
      starve_cnt_q <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_last_q    <= rr_last_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // Granted requester is forwarded combinationally to the memory port.
  always_comb begin
    mem_valid  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    inst_ready = 1'b0;
    data_ready = 1'b0;
    case (state_q)
      GRANT_INST: begin
        mem_valid  = inst_valid;
        mem_addr   = inst_addr;
        inst_ready = mem_ready;
      end
      GRANT_DATA: begin
        mem_valid  = data_valid;
        mem_addr   = data_addr;
        mem_wdata  = data_wdata;
        mem_we     = data_we;
        data_ready = mem_ready;
      end
      default: ;
    endcase
  end

  assign inst_data  = mem_rdata;
  assign data_rdata = mem_rdata;
  assign grant_data = grant_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of single transactions, scoreboard of
// ready pulses, and hand sequences for contention, abort, reset and idle noise.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic        inst_valid, data_we, data_valid, mem_ready;
  logic [31:0] inst_data, data_rdata, mem_addr, mem_wdata;
  logic        inst_ready, data_ready, mem_we, mem_valid, grant_data;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [32:0] exp_q[$];  // {is_data, rdata} per expected ready pulse

  typedef struct {
    logic        is_data;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    int          waits;
    logic        exp_gd;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];
  logic exp_order[10];

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_addr(inst_addr), .inst_valid(inst_valid), .inst_data(inst_data), .inst_ready(inst_ready),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_we(data_we), .data_valid(data_valid),
    .data_rdata(data_rdata), .data_ready(data_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant_data(grant_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    inst_valid = 1'b0; inst_addr = '0;
    data_valid = 1'b0; data_addr = '0; data_wdata = '0; data_we = 1'b0;
    mem_ready  = 1'b0; mem_rdata = '0;
  endtask

  // scoreboard: every ready pulse must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && (inst_ready || data_ready)) begin
      if (inst_ready && data_ready) begin
        chk("sb_both_ready", 64'd1, 64'd0);
      end else if (exp_q.size() == 0) begin
        chk("sb_spurious_ready", {62'd0, data_ready, inst_ready}, 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("sb_port", {63'd0, data_ready}, {63'd0, e[32]});
        chk("sb_rdata", {32'd0, data_ready ? data_rdata : inst_data}, {32'd0, e[31:0]});
      end
    end
  end

  // driver: one transaction from IDLE, optional wait states before mem_ready
  task automatic run_vec(input vec_t v);
    if (v.is_data) begin
      data_valid = 1'b1; data_addr = v.addr; data_wdata = v.wdata; data_we = v.we;
    end else begin
      inst_valid = 1'b1; inst_addr = v.addr;
      data_we = 1'b1; data_addr = ~v.addr; data_wdata = 32'hFFFF_FFFF;
    end
    #1 chk("req_latency", {63'd0, mem_valid}, 64'd0);
    tick();
    for (int w = 0; w < v.waits; w++) begin
      #1;
      chk("wait_valid", {63'd0, mem_valid}, 64'd1);
      chk("wait_grant", {63'd0, grant_data}, {63'd0, v.exp_gd});
      chk("wait_ready", {62'd0, inst_ready, data_ready}, 64'd0);
      tick();
    end
    mem_ready = 1'b1; mem_rdata = v.rdata;
    exp_q.push_back({v.is_data, v.rdata});
    #1;
    chk("fwd_valid", {63'd0, mem_valid}, 64'd1);
    chk("fwd_grant", {63'd0, grant_data}, {63'd0, v.exp_gd});
    chk("fwd_addr", {32'd0, mem_addr}, {32'd0, v.exp_addr});
    chk("fwd_we", {63'd0, mem_we}, {63'd0, v.exp_we});
    if (v.is_data) chk("fwd_wdata", {32'd0, mem_wdata}, {32'd0, v.exp_wdata});
    chk("fwd_ready", {62'd0, inst_ready, data_ready}, v.is_data ? 64'd1 : 64'd2);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("done_idle_valid", {63'd0, mem_valid}, 64'd0);
    chk("done_idle_grant", {63'd0, grant_data}, 64'd0);
    inst_valid = 1'b0; data_valid = 1'b0;
  endtask

  // both requesters valid continuously, memory answers in the first grant cycle
  task automatic run_contention(input int n);
    inst_valid = 1'b1; inst_addr = 32'h400;
    data_valid = 1'b1; data_addr = 32'h500; data_we = 1'b0;
    mem_ready  = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      mem_rdata = 32'hA000_0000 + 32'(k);
      exp_q.push_back({exp_order[k], mem_rdata});
      #1;
      chk("cont_grant", {63'd0, grant_data}, {63'd0, exp_order[k]});
      chk("cont_addr", {32'd0, mem_addr}, exp_order[k] ? 64'h500 : 64'h400);
      tick();
      #1 chk("cont_idle", {63'd0, mem_valid}, 64'd0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h100, 32'h0,  1'b0, 32'hDEADBEEF, 0, 1'b0, 32'h100, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h200, 32'h55, 1'b1, 32'h0,        0, 1'b1, 32'h200, 1'b1, 32'h55};
    vecs[2] = '{1'b1, 32'h300, 32'h0,  1'b0, 32'h12345678, 3, 1'b1, 32'h300, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h104, 32'h0,  1'b0, 32'hCAFEF00D, 1, 1'b0, 32'h104, 1'b0, 32'h0};
    vecs[4].is_data = 1'b1;
    vecs[4].addr    = $urandom;
    vecs[4].wdata   = $urandom;
    vecs[4].we      = 1'($urandom_range(0, 1));
    vecs[4].rdata   = $urandom;
    vecs[4].waits   = int'($urandom_range(0, 2));
    vecs[4].exp_gd    = 1'b1;
    vecs[4].exp_addr  = vecs[4].addr;
    vecs[4].exp_we    = vecs[4].we;
    vecs[4].exp_wdata = vecs[4].wdata;
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_order[k] = (k % 2 == 0);
`else
      exp_order[k] = (k % 5 != 4);
`endif
    end

    // reset state, with both requests already asserted
    clear_inputs();
    reset = 1'b1;
    inst_valid = 1'b1; data_valid = 1'b1;
    tick(); tick();
    #1;
    chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst_readies", {62'd0, inst_ready, data_ready}, 64'd0);
    chk("rst_grant", {63'd0, grant_data}, 64'd0);
    clear_inputs();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // idle noise
    tick();
    mem_ready = 1'b1;
    #1;
    chk("noise_readies", {62'd0, inst_ready, data_ready}, 64'd0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("noise_grant", {63'd0, grant_data}, 64'd0);
    chk("noise_valid", {63'd0, mem_valid}, 64'd0);

    // abort: data drops valid before mem_ready
    data_valid = 1'b1; data_addr = 32'h600; data_we = 1'b1; data_wdata = 32'h77;
    tick();
    #1 chk("abort_granted", {63'd0, mem_valid}, 64'd1);
    data_valid = 1'b0;
    #1;
    chk("abort_valid_drop", {63'd0, mem_valid}, 64'd0);
    chk("abort_no_ready", {63'd0, data_ready}, 64'd0);
    tick();
    #1 chk("abort_idle", {63'd0, grant_data}, 64'd0);
    data_valid = 1'b1;
    #1 chk("abort_idle_valid", {63'd0, mem_valid}, 64'd0);
    data_valid = 1'b0;
    tick();

    // reset in the middle of a contended sequence, then full sequence from scratch
    reset = 1'b1; tick(); reset = 1'b0; tick();
    run_contention(3);
    mem_ready = 1'b0;
    tick();
    #1 chk("midseq_granted", {63'd0, mem_valid}, 64'd1);
    reset = 1'b1;
    #1;
    chk("midseq_rst_valid", {63'd0, mem_valid}, 64'd0);
    chk("midseq_rst_grant", {63'd0, grant_data}, 64'd0);
    clear_inputs();
    tick(); tick();
    reset = 1'b0;
    tick();
    run_contention(10);
    clear_inputs();
    tick();

    // async reset during GRANT_INST; a late mem_ready must be ignored
    inst_valid = 1'b1; inst_addr = 32'h700;
    tick();
    #1;
    chk("inst_rst_granted", {63'd0, mem_valid}, 64'd1);
    chk("inst_rst_grant_inst", {63'd0, grant_data}, 64'd0);
    reset = 1'b1;
    #1;
    chk("inst_rst_valid", {63'd0, mem_valid}, 64'd0);
    chk("inst_rst_ready", {63'd0, inst_ready}, 64'd0);
    inst_valid = 1'b0;
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1 chk("late_ready_ignored", {62'd0, inst_ready, data_ready}, 64'd0);
    tick();
    mem_ready = 1'b0;
    tick();

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
